// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter feeding byte streams into one UART TX FIFO.
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous reset, active-high
//   req_data      requester i byte at [i*DATA_BIT +: DATA_BIT]
//   req_valid     requester i presents a byte
//   req_last      requester i byte ends its packet
//   req_ready     requester i byte accepted this cycle (when valid)
//   fifo_full     TX FIFO cannot take a byte
//   fifo_wr       TX FIFO write strobe
//   fifo_wdata    TX FIFO write data
//   grant         one-hot owner while locked, zero when idle
//   busy          locked onto a packet
//   timeout_pulse one-cycle pulse when an idle owner is forcibly released
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BIT    = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ*DATA_BIT-1:0] req_data,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DATA_BIT-1:0]         fifo_wdata,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        timeout_pulse
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] owner, owner_nx, last_grant, last_grant_nx, sel;
    logic [CW-1:0] cnt, cnt_nx;
    logic          owner_valid, xfer;

    // Index k steps past base, wrapping; NUM_REQ need not be a power of two.
    function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + 1 + k;
        return IW'(s >= NUM_REQ ? s - NUM_REQ : s);
    endfunction

    // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
    always_comb begin
        sel = rot(last_grant, 0);
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[rot(last_grant, k)]) sel = rot(last_grant, k);
    end

    assign busy          = state == LOCKED;
    assign owner_valid   = req_valid[owner];
    assign xfer          = busy && owner_valid && !fifo_full;
    assign fifo_wr       = xfer;
    assign fifo_wdata    = busy ? req_data[owner*DATA_BIT +: DATA_BIT] : '0;
    assign grant         = busy ? NUM_REQ'(1) << owner : '0;
    assign req_ready     = (busy && !fifo_full) ? grant : '0;
    // Only cycles where the owner has nothing to offer count toward release; FIFO stalls do not.
    assign timeout_pulse = busy && !owner_valid && cnt == CNT_MAX;

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        if (!busy) begin
            if (|req_valid) begin
                state_nx = LOCKED;
                owner_nx = sel;
                cnt_nx   = '0;
            end
        end else if (xfer) begin
            cnt_nx = '0;
            if (req_last[owner]) begin
                state_nx      = IDLE;
                last_grant_nx = owner;
            end
        end else if (!owner_valid) begin
            cnt_nx = cnt + 1'b1;
            if (timeout_pulse) begin
                state_nx      = IDLE;
                last_grant_nx = owner;
                cnt_nx        = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= LAST_IDX;
            cnt        <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            cnt        <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a cycle-level reference model of the packet arbiter.
module tb_uart_tx_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [N*W-1:0] req_data;
    logic [N-1:0] req_valid, req_last, req_ready, grant;
    logic fifo_full, fifo_wr, busy, timeout_pulse;
    logic [W-1:0] fifo_wdata;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BIT(W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset_n(reset_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [W:0] drv_q[N][$];
    logic [W-1:0] exp_q[N][$];
    int start_q[$];
    int m_own = -1, m_lg = N - 1, m_idle = 0;
    int cyc = 0, to_cnt = 0, to_gap = 0, wr_cyc = 0;
    bit rand_gap = 0, rand_full = 0, force_full = 0;
    logic [N-1:0] acc, held;
    logic e_busy, e_v, e_wr, e_to, found;
    logic [N-1:0] e_grant, e_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: evaluated each cycle from the inputs the DUT sees, then advanced.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            chk("rst_grant", 64'(grant), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_wr", 64'(fifo_wr), 0);
            chk("rst_ready", 64'(req_ready), 0);
            chk("rst_timeout", 64'(timeout_pulse), 0);
            m_own = -1;
            m_lg = N - 1;
            m_idle = 0;
        end else begin
            e_busy  = m_own >= 0;
            e_grant = e_busy ? N'(1) << m_own : '0;
            e_v     = e_busy ? req_valid[m_own] : 1'b0;
            e_wr    = e_v && !fifo_full;
            e_ready = (e_busy && !fifo_full) ? e_grant : '0;
            e_to    = e_busy && !e_v && (m_idle + 1 == T);
            chk("grant", 64'(grant), 64'(e_grant));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("fifo_wr", 64'(fifo_wr), 64'(e_wr));
            chk("timeout_pulse", 64'(timeout_pulse), 64'(e_to));
            if (fifo_wr) begin
                if (m_own < 0 || exp_q[m_own].size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    chk("fifo_wdata", 64'(fifo_wdata), 64'(exp_q[m_own].pop_front()));
                    wr_cyc = cyc;
                end
            end
            if (timeout_pulse) begin
                to_cnt++;
                to_gap = cyc - wr_cyc;
            end
            if (!e_busy) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++)
                    if (!found && req_valid[(m_lg + k) % N]) begin
                        found = 1'b1;
                        m_own = (m_lg + k) % N;
                        m_idle = 0;
                        start_q.push_back(m_own);
                    end
            end else if (e_wr) begin
                m_idle = 0;
                if (req_last[m_own]) begin
                    m_lg = m_own;
                    m_own = -1;
                end
            end else if (!e_v) begin
                if (e_to) begin
                    m_lg = m_own;
                    m_own = -1;
                end else m_idle++;
            end
        end
    end

    task automatic step();
        logic [W:0] e;
        @(negedge clk);
        for (int i = 0; i < N; i++) acc[i] = req_valid[i] & req_ready[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            held[i] = req_valid[i] && !acc[i];
            if (drv_q[i].size() > 0 && (held[i] || !rand_gap || $urandom_range(0, 3) != 0)) begin
                e = drv_q[i][0];
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = e[W-1:0];
                req_last[i] = e[W];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i] = 1'b0;
            end
        end
        fifo_full = force_full || (rand_full && $urandom_range(0, 3) == 0);
    endtask

    task automatic send(input int r, input int len, input logic [W-1:0] base, input bit term);
        for (int j = 0; j < len; j++) begin
            drv_q[r].push_back({term && j == len - 1, base + W'(j)});
            exp_q[r].push_back(base + W'(j));
        end
    endtask

    function automatic bit pending();
        bit p = busy;
        for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    function automatic logic [63:0] order();
        logic [63:0] v = 0;
        foreach (start_q[k]) v = v * 16 + 64'(start_q[k] + 1);
        return v;
    endfunction

    task automatic drain(input string name);
        int b = 0;
        while (pending() && b < 2000) begin
            step();
            b++;
        end
        step();
        chk(name, 64'(b < 2000), 1);
    endtask

    task automatic reset_pulse();
        reset_n = 1'b1;
        #1;
        chk("rst_now_grant", 64'(grant), 0);
        chk("rst_now_busy", 64'(busy), 0);
        chk("rst_now_wr", 64'(fifo_wr), 0);
        chk("rst_now_ready", 64'(req_ready), 0);
        chk("rst_now_timeout", 64'(timeout_pulse), 0);
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
        end
        req_valid = '0;
        req_last = '0;
        force_full = 0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_data = '0;
        req_valid = '0;
        req_last = '0;
        fifo_full = 1'b0;
        acc = '0;
        held = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;

        send(2, 3, 8'h41, 1);
        drain("single_done");
        chk("single_order", order(), 64'h3);

        reset_pulse();
        start_q.delete();
        send(0, 2, 8'h10, 1);
        send(1, 2, 8'h20, 1);
        send(3, 2, 8'h30, 1);
        drain("contend1_done");
        send(0, 2, 8'h50, 1);
        send(1, 2, 8'h60, 1);
        send(3, 2, 8'h70, 1);
        drain("contend2_done");
        chk("contend_order", order(), 64'h124124);

        start_q.delete();
        send(0, 2, 8'h80, 1);
        send(2, 2, 8'h90, 1);
        drain("wrap_done");
        chk("wrap_order", order(), 64'h13);

        to_cnt = 0;
        send(1, 4, 8'hA0, 1);
        repeat (3) step();
        force_full = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            chk("bp_wr", 64'(fifo_wr), 0);
            chk("bp_ready", 64'(req_ready), 0);
            chk("bp_grant", 64'(grant), 64'h2);
            chk("bp_timeout", 64'(timeout_pulse), 0);
        end
        force_full = 0;
        drain("bp_done");
        chk("bp_no_timeout", 64'(to_cnt), 0);

        reset_pulse();
        start_q.delete();
        to_cnt = 0;
        send(0, 1, 8'hC5, 0);
        send(1, 2, 8'hD0, 1);
        drain("timeout_done");
        chk("timeout_count", 64'(to_cnt), 1);
        chk("timeout_gap", 64'(to_gap), T);
        chk("timeout_order", order(), 64'h12);

        send(3, 4, 8'hE0, 1);
        repeat (3) step();
        reset_pulse();
        start_q.delete();
        send(0, 2, 8'hF0, 1);
        send(2, 2, 8'hF8, 1);
        drain("rst_mid_done");
        chk("rst_mid_order", order(), 64'h13);

        rand_gap = 1;
        rand_full = 1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0)
                send($urandom_range(0, N - 1), $urandom_range(1, 4), W'($urandom), 1);
            step();
        end
        drain("rand_done");
        for (int i = 0; i < N; i++) chk("rand_leftover", 64'(exp_q[i].size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
